// File: rtl/systolic_skew_feeder.sv
// Edge feeder for an NxN systolic MAC array: buffers K operand vectors, then emits a
// one-cycle array clear followed by the diagonally skewed stream. Optional: SKEW_FEEDER_REPLAY_EN.
module systolic_skew_feeder #(
   parameter int N     = 4,
   parameter int DW    = 32,
   parameter int DEPTH = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*DW-1:0] in_data,
   input  logic            in_last,
   input  logic            start,
   output logic            arr_clr,
   output logic            out_valid,
   output logic [N*DW-1:0] out_data,
   output logic            busy,
   output logic            done
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SW = $clog2(DEPTH + N + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_READY, S_CLEAR, S_STREAM, S_DRAIN, S_DONE
   } state_t;

   state_t              state_q, state_n;
   logic [CW-1:0]       cnt_q, cnt_n;
   logic [SW-1:0]       s_q, s_n;
   logic [N*DW-1:0]     tile_q [DEPTH];
   logic                wr_en;
   logic [AW-1:0]       wr_idx;
   logic                accept;
   logic [N-1:0][DW-1:0] lane_n;

   assign accept = in_valid & in_ready;

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      s_n     = s_q;
      wr_en   = 1'b0;
      wr_idx  = '0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               wr_en   = 1'b1;
               cnt_n   = CW'(1);
               state_n = (in_last || DEPTH == 1) ? S_READY : S_LOAD;
            end
`ifdef SKEW_FEEDER_REPLAY_EN
            else if (start && cnt_q != '0) begin
               state_n = S_CLEAR;
            end
`endif
         end
         S_LOAD: begin
            if (accept) begin
               wr_en  = 1'b1;
               wr_idx = cnt_q[AW-1:0];
               cnt_n  = cnt_q + CW'(1);
               if (in_last || cnt_n == CW'(DEPTH))
                  state_n = S_READY;
            end
         end
         S_READY: begin
            if (start)
               state_n = S_CLEAR;
         end
         S_CLEAR: begin
            state_n = S_STREAM;
            s_n     = '0;
         end
         S_STREAM: begin
            // K+N-1 steps: the last lane needs N-1 extra steps to emit its final element
            if (s_q + SW'(1) == SW'(cnt_q) + SW'(N - 1)) begin
               s_n     = '0;
               state_n = (N > 1) ? S_DRAIN : S_DONE;
            end else begin
               s_n = s_q + SW'(1);
            end
         end
         S_DRAIN: begin
            if (s_q + SW'(1) == SW'(N - 1))
               state_n = S_DONE;
            else
               s_n = s_q + SW'(1);
         end
         S_DONE: begin
            state_n = S_IDLE;
`ifndef SKEW_FEEDER_REPLAY_EN
            cnt_n   = '0;
`endif
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Outputs are registered, so the next stream vector is built from the next step index.
   always_comb begin
      int d;
      d = 0;
      for (int i = 0; i < N; i++) begin
         lane_n[i] = '0;
         d = int'(s_n) - i;
         if (state_n == S_STREAM && d >= 0 && d < int'(cnt_q))
            lane_n[i] = tile_q[d[AW-1:0]][i*DW +: DW];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         s_q       <= '0;
         in_ready  <= 1'b1;
         arr_clr   <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_n;
         cnt_q     <= cnt_n;
         s_q       <= s_n;
         in_ready  <= (state_n == S_IDLE) ||
                      (state_n == S_LOAD && cnt_n < CW'(DEPTH));
         arr_clr   <= (state_n == S_CLEAR);
         out_valid <= (state_n == S_STREAM);
         out_data  <= lane_n;
         busy      <= (state_n == S_CLEAR) || (state_n == S_STREAM) ||
                      (state_n == S_DRAIN);
         done      <= (state_n == S_DONE);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         tile_q[wr_idx] <= in_data;
   end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: a cycle-count model of the tile schedule
// checked every cycle, plus literal expectations for the K=3 stream and full-buffer cases.
module tb_systolic_skew_feeder;
   localparam int N = 4, DW = 32, DEPTH = 8;
`ifdef SKEW_FEEDER_REPLAY_EN
   localparam bit REPLAY = 1'b1;
`else
   localparam bit REPLAY = 1'b0;
`endif

   logic            clk, rst, in_valid, in_ready, in_last, start;
   logic            arr_clr, out_valid, busy, done;
   logic [N*DW-1:0] in_data, out_data;

   int vec_cnt = 0, err_cnt = 0;
   bit chk_en = 1'b0;

   systolic_skew_feeder #(.N(N), .DW(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .start(start), .arr_clr(arr_clr),
      .out_valid(out_valid), .out_data(out_data), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: m_t counts cycles since an accepted start (1=clear, 2..K+N stream,
   // then N-1 drain cycles, K+2N done); 0 means idle or loading.
   int  m_t, m_cnt, m_nc;
   bit  m_loaded, m_idle;
   logic [DW-1:0] m_tile [DEPTH][N];
   assign m_nc = (m_idle ? 0 : m_cnt) + 1;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_t <= 0; m_cnt <= 0; m_loaded <= 1'b0; m_idle <= 1'b1;
      end else if (m_t != 0) begin
         if (m_t == m_cnt + 2*N) begin
            m_t <= 0; m_idle <= 1'b1; m_loaded <= 1'b0;
            if (!REPLAY) m_cnt <= 0;
         end else begin
            m_t <= m_t + 1;
         end
      end else if (in_valid && !m_loaded) begin
         for (int i = 0; i < N; i++)
            m_tile[m_idle ? 0 : m_cnt][i] <= in_data[i*DW +: DW];
         m_cnt    <= m_nc;
         m_loaded <= in_last || (m_nc == DEPTH);
         m_idle   <= 1'b0;
      end else if (start && (m_loaded || (REPLAY && m_idle && m_cnt > 0))) begin
         m_t <= 1;
      end
   end

   always @(negedge clk) begin
      logic [N*DW-1:0] e;
      int d;
      if (chk_en) begin
         e = '0;
         if (m_t >= 2 && m_t <= m_cnt + N)
            for (int i = 0; i < N; i++) begin
               d = m_t - 2 - i;
               if (d >= 0 && d < m_cnt) e[i*DW +: DW] = m_tile[d][i];
            end
         chk("arr_clr",   arr_clr,   m_t == 1);
         chk("out_valid", out_valid, m_t >= 2 && m_t <= m_cnt + N);
         chk("busy",      busy,      m_t >= 1 && m_t <= m_cnt + 2*N - 1);
         chk("done",      done,      m_t == m_cnt + 2*N);
         chk("in_ready",  in_ready,  m_t == 0 && !m_loaded);
         chk("out_data",  out_data,  e);
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic load(input int k, input bit last);
      for (int j = 0; j < k; j++) begin
         in_valid = 1'b1;
         for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 32'(10*j + i + 1);
         in_last = last && (j == k - 1);
         tick();
      end
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic run_k3(input bit do_load, input bit mid_start);
      int l0[6] = '{1, 11, 21, 0, 0, 0};
      int l1[6] = '{0, 2, 12, 22, 0, 0};
      int l3[6] = '{0, 0, 0, 4, 14, 24};
      int busy_n = 0;
      if (do_load) load(3, 1'b1);
      start = 1'b1; tick(); start = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (c == 0) chk("k3_clr", arr_clr, 1);
         if (c >= 1 && c <= 6) begin
            chk("k3_valid", out_valid, 1);
            chk("k3_lane0", out_data[0*DW +: DW], l0[c-1]);
            chk("k3_lane1", out_data[1*DW +: DW], l1[c-1]);
            chk("k3_lane3", out_data[3*DW +: DW], l3[c-1]);
         end
         if (c == 10) chk("k3_done", done, 1);
         if (busy) busy_n++;
         start = mid_start && (c == 3);
         tick();
      end
      start = 1'b0;
      chk("k3_busy_len", busy_n, 10);
   endtask

   initial begin
      int ov;
      rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; start = 1'b0; in_data = '0;
      #2 rst = 1'b1;
      #1;
      chk("rst_out_data", out_data, 0);
      chk("rst_arr_clr",  arr_clr,  0);
      chk("rst_busy",     busy,     0);
      chk("rst_in_ready", in_ready, 1);
      chk_en = 1'b1;
      @(negedge clk); rst = 1'b0;
      tick();

      // start with nothing buffered
      start = 1'b1; tick(); start = 1'b0;
      chk("idle_start_clr",  arr_clr, 0);
      chk("idle_start_busy", busy,    0);
      tick();

      run_k3(1'b1, 1'b0);
      run_k3(1'b1, 1'b1);

      // full buffer: nine beats offered, eight fit
      for (int j = 0; j < 9; j++) begin
         in_valid = 1'b1; in_last = 1'b0;
         for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 32'(10*j + i + 1);
         if (j == 8) chk("full_ready", in_ready, 0);
         tick();
      end
      in_valid = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      ov = 0;
      for (int c = 0; c < 18; c++) begin
         if (out_valid) ov++;
         if (c == 11) chk("full_last_lane0", out_data[0*DW +: DW], 0);
         if (c == 8)  chk("full_k8_lane0", out_data[0*DW +: DW], 71);
         tick();
      end
      chk("full_stream_len", ov, 11);

      // async reset in the middle of the stream, at s=2
      load(3, 1'b1);
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick(); tick();
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_data",  out_data,  0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_busy",  busy,      0);
      chk("mid_rst_ready", in_ready,  1);
      @(negedge clk); #1 rst = 1'b0;
      tick();
      run_k3(1'b1, 1'b0);

`ifdef SKEW_FEEDER_REPLAY_EN
      run_k3(1'b0, 1'b0);
`endif
      tick(); tick();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
